scmp_sio: RTL and testbench

SCMP_SIO -- requirements
Module: scmp_sio

---
 rtl/scmp_sio.sv | 131 +++++++++++++
 tb/tb_scmp_sio.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/scmp_sio.sv
`default_nettype none
// ============================================================================
// Module   : scmp_sio
// Brief    : SC/MP-style serial shifter, LSB out on sout_o, sin_i into bit 7.
// Revision : 1.0 - initial release
// ============================================================================
module scmp_sio #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [7:0]       tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   input  logic             sin_i,
   output logic             sout_o,
   output logic [7:0]       rx_data_o,
   output logic             rx_valid_o,
   output logic             busy_o
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic [7:0]       r_shreg;
   logic [DIV_W-1:0] r_period;
   logic [DIV_W-1:0] r_div_cnt;
   logic [2:0]       r_bit_cnt;
   logic             r_sout;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             w_accept;
   logic             w_bit_end;
   logic             w_last;
   logic [7:0]       w_shift_val;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_bit_end   = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tx_valid_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_div_cnt == r_period) begin
               w_bit_end = 1'b1;
               if (r_bit_cnt == 3'd7) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Synchronizer idles high so a released reset does not inject a 0 bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= sin_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_shift_val = {r_sync2, r_shreg[7:1]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shreg    <= 8'h00;
         r_period   <= '0;
         r_div_cnt  <= '0;
         r_bit_cnt  <= 3'd0;
         r_sout     <= 1'b1;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_accept) begin
            r_shreg   <= tx_data_i;
            r_period  <= div_i;
            r_div_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_sout    <= tx_data_i[0];
         end else if (w_bit_end) begin
            r_shreg   <= w_shift_val;
            r_div_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            // After the final shift sout keeps the last bit sent while idle.
            if (w_last) begin
               r_rx_data  <= w_shift_val;
               r_rx_valid <= 1'b1;
            end else begin
               r_sout <= r_shreg[1];
            end
         end else if (r_state == S_SHIFT) begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
      end
   end

   assign tx_ready_o = (r_state == S_IDLE);
   assign busy_o     = ~tx_ready_o;
   assign sout_o     = r_sout;
   assign rx_data_o  = r_rx_data;
   assign rx_valid_o = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_scmp_sio.sv
`default_nettype none
// ============================================================================
// Module   : tb_scmp_sio
// Brief    : Scoreboard bench for scmp_sio with randomized transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scmp_sio;

   localparam int DIV_W = 8;

   logic             clk;
   logic             rst;
   logic [DIV_W-1:0] div;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             sin_w;
   logic             sout;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             busy;
   logic [1:0]       sin_mode;   // 0: hold 0, 1: hold 1, 2: loopback

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] data;
      logic [7:0] rx;
      int         p;
      int         n;
   } xfer_t;

   xfer_t exp_q[$];

   assign sin_w = (sin_mode == 2'd2) ? sout : sin_mode[0];

   scmp_sio #(.DIV_W(DIV_W)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .div_i      (div),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .sin_i      (sin_w),
      .sout_o     (sout),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .busy_o     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [7:0] d, input int p, input logic [1:0] mode,
                       input bit hold, output int n_acc);
      int    guard;
      xfer_t t;
      guard = 0;
      n_acc = -1;
      while (!tx_ready && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (!tx_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      if (mode != sin_mode) begin
         sin_mode = mode;
         repeat (3) @(negedge clk);
      end
      tx_data  = d;
      div      = p[DIV_W-1:0];
      tx_valid = 1'b1;
      t.data   = d;
      t.p      = p;
      t.n      = cyc;
      t.rx     = (mode == 2'd2) ? d : ((mode == 2'd1) ? 8'hFF : 8'h00);
      n_acc    = cyc;
      exp_q.push_back(t);
      @(negedge clk);
      div     = ~p[DIV_W-1:0];
      tx_data = 8'($urandom);
      if (hold) repeat (8 * (p + 1)) @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Monitor: reference behaviour derived from transfer start, period and data.
   initial begin : monitor
      int         run;
      logic       last_bit;
      logic [7:0] last_rx;
      xfer_t      t;
      int         bidx;
      run      = 0;
      last_bit = 1'b1;
      last_rx  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            run      = 0;
            last_bit = 1'b1;
            last_rx  = 8'h00;
         end else begin
            if (!tx_ready) run++;
            if (exp_q.size() > 0 && cyc > exp_q[0].n + 8 * (exp_q[0].p + 1) + 1) begin
               chk("rx_timeout", 0, 1);
               void'(exp_q.pop_front());
            end
            if (rx_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rx", 1, 0);
               end else begin
                  t = exp_q.pop_front();
                  chk("rx_data", int'(rx_data), int'(t.rx));
                  chk("rx_time", cyc, t.n + 8 * (t.p + 1) + 1);
                  chk("ready_low_len", run, 8 * (t.p + 1));
                  chk("ready_at_rx", int'(tx_ready), 1);
                  last_bit = t.data[7];
                  last_rx  = t.rx;
               end
            end else begin
               chk("rx_hold", int'(rx_data), int'(last_rx));
            end
            if (tx_ready) run = 0;
            if (exp_q.size() > 0 && cyc >= exp_q[0].n + 1) begin
               bidx = (cyc - exp_q[0].n - 1) / (exp_q[0].p + 1);
               chk("sout_bit", int'(sout), int'(exp_q[0].data[bidx]));
            end else begin
               chk("sout_idle", int'(sout), int'(last_bit));
            end
            chk("busy", int'(busy), int'(!tx_ready));
         end
      end
   end

   initial begin : stim
      int n1;
      int n2;
      int p;
      int guard;
      logic [1:0] m;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      div      = '0;
      sin_mode = 2'd1;
      #12;
      chk("rst_ready", int'(tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sout", int'(sout), 1);
      chk("rst_rx_valid", int'(rx_valid), 0);
      chk("rst_rx_data", int'(rx_data), 0);
      @(negedge clk);
      rst = 1'b0;

      send(8'hA5, 0, 2'd1, 1'b0, n1);
      send(8'h3C, 3, 2'd2, 1'b0, n1);
      send(8'hFF, 0, 2'd0, 1'b0, n1);
      send(8'h0F, 0, 2'd0, 1'b0, n2);
      chk("no_gap", n2, n1 + 9);
      send(8'h96, 255, 2'd1, 1'b0, n1);
      send(8'($urandom), 2, 2'd1, 1'b1, n1);

      // Abort a transfer with an asynchronous reset between clock edges.
      send(8'h5A, 1, 2'd1, 1'b0, n1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_ready", int'(tx_ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_sout", int'(sout), 1);
      chk("abort_rx_valid", int'(rx_valid), 0);
      chk("abort_rx_data", int'(rx_data), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(8'hC3, 0, 2'd1, 1'b0, n1);

      for (int i = 0; i < 25; i++) begin
         p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
         m = (p >= 2) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 1));
         send(8'($urandom), p, m, ($urandom_range(0, 4) == 0), n1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() > 0) chk("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
